bias_ctl_n: RTL and testbench
=============================

BIAS_CTL_N -- requirements
Module: bias_ctl_n

Interface
REQ-001 Parameter NCH, default 3: number of bias channels, legal 1..8.
REQ-002 Parameter HOLD, default 1000: post-trip holdoff length in clk cycles, legal 1..65535.
REQ-003 Ports clk and rst; rst is asynchronous and active-high; single clock domain.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 SCK  input  1  serial clock, asynchronous to clk, at most clk/4.
REQ-007 SDI  input  1  serial data, sampled on SCK rising edge.
REQ-008 STR  input  1  strobe; its rising edge executes the command frame.
REQ-009 Trip  input  NCH  per-channel fault, active-high level, asynchronous.
REQ-010 ON  input  NCH  per-channel local enable request, asynchronous; acts on its rising edge.
REQ-011 OFF  input  NCH  per-channel local disable request, asynchronous; acts on its rising edge.
REQ-012 Enable  output  NCH  per-channel bias enable, registered.
REQ-013 SDO  output  1  serial readback, MSB of shift register.

Function
REQ-014 SCK, SDI, STR, Trip, ON, OFF each pass through a 2-flop synchroniser; edges are detected on synchronised values.
REQ-015 Shift register width 3*NCH; on each synchronised SCK rising edge with STR low, it shifts left with SDI entering bit 0.
REQ-016 Command bits per channel k: bit 3k = on, bit 3k+1 = off, bit 3k+2 = clr_trip; they apply for exactly one clk on the STR rising edge.
REQ-017 On the same STR rising edge, the shift register loads status per channel k: bit 3k = Enable[k], bit 3k+1 = trip_latched[k], bit 3k+2 = synchronised Trip[k].
REQ-018 Each channel has an FSM with states OFF, ON, TRIPPED, HOLDOFF; Enable[k] is high only in ON.
REQ-019 Transition OFF->ON on (cmd on or ON edge) when synchronised Trip low and no off request in the same cycle.
REQ-020 Transition ON->OFF on cmd off or OFF edge.
REQ-021 Transition any state->TRIPPED while synchronised Trip high; trip has priority over all other requests.
REQ-022 Transition TRIPPED->HOLDOFF on cmd clr_trip with synchronised Trip low; clr_trip is ignored while Trip is high.
REQ-023 HOLDOFF loads a counter with HOLD-1, decrements each clk, and moves to OFF the cycle after it reaches 0; on/off requests during HOLDOFF are ignored.
REQ-024 trip_latched[k] is high in TRIPPED and HOLDOFF.
REQ-025 Simultaneous on and off requests: off wins and the FSM goes to or stays in OFF.
REQ-026 Trip-to-Enable-low latency is at most 4 clk from Trip assertion (2 sync, 1 FSM, 1 output register).
REQ-027 An STR edge mid-frame executes whatever bits are present; there is no frame-length check.

Reset
REQ-028 rst asserts all FSMs to OFF, Enable = 0, SDO = 0, shift register = 0, holdoff counters = 0, and synchroniser flops = 0 immediately, without waiting for clk.
REQ-029 Edge detectors do not report edges on the first clk after rst deasserts.

Structure
REQ-030 Package bias_ctl_pkg holds the channel state enum and the command/status bit-offset constants (ON_BIT=0, OFF_BIT=1, CLR_BIT=2, BITS_PER_CH=3).
REQ-031 Sub-module bias_chan implements one channel FSM and holdoff counter; bias_ctl_n instantiates it NCH times in a generate loop.

Verification
REQ-032 Shift 9 bits 001_001_001 (NCH=3) then STR -> Enable = 3'b111 within 6 clk; a following readback frame returns status 3'b001 per channel.
REQ-033 Channel 2 ON, assert Trip[2] -> Enable[2] low within 4 clk, trip_latched set; ON[2] edge while tripped leaves Enable[2] = 0.
REQ-034 Trip[2] low, send clr_trip (HOLD=20) -> OFF exactly 20 clk after command; an ON edge at cycle 10 is ignored; an ON edge at cycle 25 gives Enable[2] = 1.
REQ-035 Same-frame on and off for channel 0 -> Enable[0] stays 0; concurrent OFF edge and cmd on -> 0.
REQ-036 rst asserted mid-holdoff and mid-frame -> all outputs 0 with no clk edge; after release, no spurious enable from stale SCK or ON levels.

Source files
------------

// File: rtl/bias_ctl_pkg.sv
// Shared types and serial-frame bit offsets for the bias controller.
package bias_ctl_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON       = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_HOLDOFF  = 2'd3
    } chan_state_e;

    // Per-channel field layout, shared by command and status frames.
    localparam int ON_BIT      = 0;
    localparam int OFF_BIT     = 1;
    localparam int CLR_BIT     = 2;
    localparam int BITS_PER_CH = 3;

endpackage

// File: rtl/bias_chan.sv
// One bias channel: OFF/ON/TRIPPED/HOLDOFF state machine with post-trip holdoff counter.
// Inputs are already synchronised single-cycle requests; enable is registered after the state.
module bias_chan
    import bias_ctl_pkg::*;
#(
    parameter int HOLD = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trip_i,
    input  logic on_i,
    input  logic off_i,
    input  logic clr_i,
    output logic enable_o,
    output logic trip_latched_o
);

    localparam logic [15:0] HOLD_M1 = 16'(HOLD - 1);

    chan_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        enable_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= (state_q == ST_ON);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A live fault overrides every request, including a clear.
        if (trip_i) begin
            state_d = ST_TRIPPED;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (on_i && !off_i) state_d = ST_ON;
                end
                ST_ON: begin
                    if (off_i) state_d = ST_OFF;
                end
                ST_TRIPPED: begin
                    if (clr_i) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_M1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == 16'd0) state_d = ST_OFF;
                    else                cnt_d   = cnt_q - 16'd1;
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    assign enable_o       = enable_q;
    assign trip_latched_o = (state_q == ST_TRIPPED) || (state_q == ST_HOLDOFF);

endmodule

// File: rtl/bias_ctl_n.sv
// Multi-channel bias enable controller with a serial command/status port and local ON/OFF/Trip inputs.
// All asynchronous inputs are double-flopped; edges are only reported once the synchronisers have refilled after reset.
module bias_ctl_n
    import bias_ctl_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int HOLD = 1000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           SCK,
    input  logic           SDI,
    input  logic           STR,
    input  logic [NCH-1:0] Trip,
    input  logic [NCH-1:0] ON,
    input  logic [NCH-1:0] OFF,
    output logic [NCH-1:0] Enable,
    output logic           SDO
);

    localparam int W  = BITS_PER_CH * NCH;
    localparam int SW = 3 * NCH + 3;

    logic [SW-1:0]  async_in, sync1_q, sync2_q;
    logic           sck_s, sdi_s, str_s;
    logic [NCH-1:0] trip_s, on_s, off_s;

    logic           sck_prev_q, str_prev_q;
    logic [NCH-1:0] on_prev_q, off_prev_q;
    logic [1:0]     arm_q;
    logic           armed;
    logic           sck_rise, str_rise;
    logic [NCH-1:0] on_rise, off_rise;

    logic [W-1:0]   sr_q, sr_d, status, cmd;
    logic [NCH-1:0] trip_latched;

    assign async_in = {OFF, ON, Trip, STR, SDI, SCK};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
        end
    end

    assign sck_s  = sync2_q[0];
    assign sdi_s  = sync2_q[1];
    assign str_s  = sync2_q[2];
    assign trip_s = sync2_q[3 +: NCH];
    assign on_s   = sync2_q[3 + NCH +: NCH];
    assign off_s  = sync2_q[3 + 2*NCH +: NCH];

    // Edges stay masked until the sync chain and the previous-value flops
    // both hold post-reset samples, so levels present at release never fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev_q <= 1'b0;
            str_prev_q <= 1'b0;
            on_prev_q  <= '0;
            off_prev_q <= '0;
            arm_q      <= '0;
        end else begin
            sck_prev_q <= sck_s;
            str_prev_q <= str_s;
            on_prev_q  <= on_s;
            off_prev_q <= off_s;
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
        end
    end

    assign armed    = (arm_q == 2'd3);
    assign sck_rise = armed & sck_s & ~sck_prev_q;
    assign str_rise = armed & str_s & ~str_prev_q;
    assign on_rise  = {NCH{armed}} & on_s & ~on_prev_q;
    assign off_rise = {NCH{armed}} & off_s & ~off_prev_q;

    always_comb begin
        status = '0;
        for (int k = 0; k < NCH; k++) begin
            status[BITS_PER_CH*k + ON_BIT]  = Enable[k];
            status[BITS_PER_CH*k + OFF_BIT] = trip_latched[k];
            status[BITS_PER_CH*k + CLR_BIT] = trip_s[k];
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (str_rise)                sr_d = status;
        else if (sck_rise && !str_s) sr_d = {sr_q[W-2:0], sdi_s};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    // The frame in the shift register is executed for exactly the strobe cycle.
    assign cmd = str_rise ? sr_q : '0;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        bias_chan #(.HOLD(HOLD)) u_chan (
            .clk_i          (clk),
            .rst_i          (rst),
            .trip_i         (trip_s[k]),
            .on_i           (cmd[BITS_PER_CH*k + ON_BIT]  | on_rise[k]),
            .off_i          (cmd[BITS_PER_CH*k + OFF_BIT] | off_rise[k]),
            .clr_i          (cmd[BITS_PER_CH*k + CLR_BIT]),
            .enable_o       (Enable[k]),
            .trip_latched_o (trip_latched[k])
        );
    end

    assign SDO = sr_q[W-1];

endmodule

// File: tb/tb_bias_ctl_n.sv
// Directed bench for bias_ctl_n (NCH=3, HOLD=20): serial commands, readback, trip/holdoff timing, reset.
module tb_bias_ctl_n;

    localparam int NCH  = 3;
    localparam int HOLD = 20;

    logic           clk, rst, SCK, SDI, STR, SDO;
    logic [NCH-1:0] Trip, ON, OFF, Enable;
    logic [8:0]     rd;
    logic           en_b, en_a;
    int             checks = 0;
    int             errors = 0;

    bias_ctl_n #(.NCH(NCH), .HOLD(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .SCK    (SCK),
        .SDI    (SDI),
        .STR    (STR),
        .Trip   (Trip),
        .ON     (ON),
        .OFF    (OFF),
        .Enable (Enable),
        .SDO    (SDO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        SDI = b;
        wait_clk(4);
        SCK = 1'b1;
        wait_clk(4);
        SCK = 1'b0;
    endtask

    task automatic shift_frame(input logic [8:0] f);
        for (int i = 8; i >= 0; i--) shift_bit(f[i]);
        wait_clk(4);
    endtask

    task automatic strobe();
        STR = 1'b1;
        wait_clk(4);
        STR = 1'b0;
        wait_clk(4);
    endtask

    task automatic cmd_frame(input logic [8:0] f);
        shift_frame(f);
        strobe();
    endtask

    // Executes a no-op frame to capture status, then shifts it out MSB first.
    task automatic readback(output logic [8:0] r);
        cmd_frame(9'd0);
        for (int i = 8; i >= 0; i--) begin
            r[i] = SDO;
            shift_bit(1'b0);
        end
        wait_clk(4);
    endtask

    task automatic pulse(input logic [2:0] on_v, input logic [2:0] off_v);
        ON  = on_v;
        OFF = off_v;
        wait_clk(4);
        ON  = '0;
        OFF = '0;
        wait_clk(4);
    endtask

    // Sends clr_trip for ch2; c counts clk cycles from the command edge.
    // An ON raised at negedge c is evaluated by the channel at command+c.
    task automatic holdoff_run(input int p1, input int p2, input int pa,
                               output logic eb, output logic ea);
        shift_frame(9'b100_000_000);
        eb = 1'bx;
        ea = 1'bx;
        for (int c = 0; c <= pa + 5; c++) begin
            STR = (c < 4);
            ON  = {((c >= p1 && c < p1 + 2) || (c >= p2 && c < p2 + 2) ||
                    (c >= pa && c < pa + 2)), 2'b00};
            if (c == pa)     eb = Enable[2];
            if (c == pa + 5) ea = Enable[2];
            @(negedge clk);
        end
        ON = '0;
        wait_clk(4);
    endtask

    initial begin
        rst = 1'b1; SCK = 1'b0; SDI = 1'b0; STR = 1'b0;
        Trip = '0; ON = '0; OFF = '0;
        #1;
        check("reset_enable", {6'd0, Enable}, 9'd0);
        check("reset_sdo", {8'd0, SDO}, 9'd0);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(5);

        // Serial enable of all channels, then status readback.
        shift_frame(9'b001_001_001);
        STR = 1'b1;
        wait_clk(2);
        check("str_enable_early", {6'd0, Enable}, 9'b000);
        wait_clk(4);
        check("str_enable_6clk", {6'd0, Enable}, 9'b111);
        STR = 1'b0;
        wait_clk(4);
        readback(rd);
        check("status_all_on", rd, 9'b001_001_001);

        // Trip on channel 2 and ON edge while tripped.
        Trip = 3'b100;
        wait_clk(4);
        check("trip_latency", {6'd0, Enable}, 9'b011);
        pulse(3'b100, 3'b000);
        check("on_while_tripped", {6'd0, Enable}, 9'b011);
        readback(rd);
        check("status_tripped", rd, 9'b110_001_001);

        // clr_trip while Trip is still high must be ignored.
        cmd_frame(9'b100_000_000);
        readback(rd);
        check("clr_while_trip", rd, 9'b110_001_001);
        Trip = '0;
        wait_clk(4);
        readback(rd);
        check("status_trip_low", rd, 9'b010_001_001);

        // Holdoff: ON at 10 and 20 ignored, ON at 25 accepted.
        holdoff_run(10, 20, 25, en_b, en_a);
        check("holdoff_ignores_on", {8'd0, en_b}, 9'd0);
        check("on_after_holdoff", {8'd0, en_a}, 9'd1);
        Trip = 3'b100;
        wait_clk(4);
        check("retrip", {6'd0, Enable}, 9'b011);
        Trip = '0;
        wait_clk(4);
        // OFF is reached exactly 20 clk after the command, so ON at 21 is accepted.
        holdoff_run(5, 15, 21, en_b, en_a);
        check("holdoff_ignores_on_2", {8'd0, en_b}, 9'd0);
        check("on_at_holdoff_end", {8'd0, en_a}, 9'd1);
        readback(rd);
        check("status_recovered", rd, 9'b001_001_001);

        // On/off conflicts on channel 0.
        cmd_frame(9'b000_000_010);
        check("cmd_off_ch0", {6'd0, Enable}, 9'b110);
        cmd_frame(9'b000_000_011);
        check("same_frame_on_off", {6'd0, Enable}, 9'b110);
        shift_frame(9'b000_000_001);
        STR = 1'b1;
        OFF = 3'b001;
        wait_clk(4);
        STR = 1'b0;
        OFF = '0;
        wait_clk(4);
        check("off_edge_vs_cmd_on", {6'd0, Enable}, 9'b110);
        pulse(3'b000, 3'b010);
        check("off_edge_ch1", {6'd0, Enable}, 9'b100);
        pulse(3'b010, 3'b000);
        check("on_edge_ch1", {6'd0, Enable}, 9'b110);
        cmd_frame(9'b000_000_001);
        check("cmd_on_ch0", {6'd0, Enable}, 9'b111);

        // Reset mid-holdoff and mid-frame with stale SCK/ON levels.
        Trip = 3'b100;
        wait_clk(4);
        Trip = '0;
        wait_clk(4);
        cmd_frame(9'b100_000_000);
        SDI = 1'b1;
        wait_clk(4);
        SCK = 1'b1;
        wait_clk(4);
        check("pre_reset_sdo", {8'd0, SDO}, 9'd1);
        check("pre_reset_enable", {6'd0, Enable}, 9'b011);
        ON = 3'b111;
        #2 rst = 1'b1;
        #1;
        check("async_reset_enable", {6'd0, Enable}, 9'd0);
        check("async_reset_sdo", {8'd0, SDO}, 9'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        check("post_reset_enable", {6'd0, Enable}, 9'd0);
        check("post_reset_sdo", {8'd0, SDO}, 9'd0);
        SCK = 1'b0;
        ON  = '0;
        SDI = 1'b0;
        wait_clk(4);
        pulse(3'b101, 3'b000);
        check("post_reset_on", {6'd0, Enable}, 9'b101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
